// File: rtl/mem_dma_copier.sv
`default_nettype none
// ============================================================================
// Module   : mem_dma_copier
// Purpose  : Word-by-word DMA copier mastering the PicoRV32 native memory bus.
//            Optional constant-fill mode is compiled in with MEM_DMA_FILL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_dma_copier #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cfg_start,
    input  logic [31:0]      cfg_src,
    input  logic [31:0]      cfg_dst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_fill,
    input  logic [31:0]      cfg_pattern,
    input  logic             cfg_abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             mem_valid,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_REQ = 3'd1,
        S_RD_GAP = 3'd2,
        S_WR_REQ = 3'd3,
        S_WR_GAP = 3'd4
    } state_t;

    localparam logic [3:0]  c_STRB_RD = 4'b0000;
    localparam logic [3:0]  c_STRB_WR = 4'b1111;
    localparam logic [31:0] c_WORD    = 32'd4;

    state_t           r_state, w_state;
    logic [31:0]      r_src, w_src, r_dst, w_dst;
    logic [31:0]      r_addr, w_addr, r_wdata, w_wdata;
    logic [LEN_W-1:0] r_rem, w_rem;
    logic [3:0]       r_wstrb, w_wstrb;
    logic             r_valid, w_valid, r_busy, w_busy;
    logic             r_done, w_done, r_aborted, w_aborted;
    logic             w_xfer, w_accept;
    logic             w_fill_req, w_fill_mode;
    logic [31:0]      w_pattern;
    logic             w_unused_lsb;

    assign w_unused_lsb = ^{cfg_src[1:0], cfg_dst[1:0]};
    assign w_xfer       = r_valid && mem_ready;
    // a zero-length job leaves busy set for one IDLE cycle; starts are ignored then
    assign w_accept     = (r_state == S_IDLE) && !r_busy && cfg_start;

`ifdef MEM_DMA_FILL_EN
    logic r_fill;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fill <= 1'b0;
        end else if (w_accept) begin
            r_fill <= cfg_fill;
        end
    end

    assign w_fill_req  = cfg_fill;
    assign w_fill_mode = r_fill;
    assign w_pattern   = cfg_pattern;
`else
    logic w_unused_fill;

    assign w_unused_fill = ^{cfg_fill, cfg_pattern};
    assign w_fill_req    = 1'b0;
    assign w_fill_mode   = 1'b0;
    assign w_pattern     = 32'd0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_src     <= 32'd0;
            r_dst     <= 32'd0;
            r_rem     <= '0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_src     <= w_src;
            r_dst     <= w_dst;
            r_rem     <= w_rem;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_wstrb   <= w_wstrb;
            r_valid   <= w_valid;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_aborted <= w_aborted;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_src     = r_src;
        w_dst     = r_dst;
        w_rem     = r_rem;
        w_addr    = r_addr;
        w_wdata   = r_wdata;
        w_wstrb   = r_wstrb;
        w_valid   = r_valid;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_aborted = r_aborted;
        case (r_state)
            S_IDLE: begin
                if (r_busy) begin
                    w_busy = 1'b0;
                end else if (w_accept) begin
                    w_src     = {cfg_src[31:2], 2'b00};
                    w_dst     = {cfg_dst[31:2], 2'b00};
                    w_rem     = cfg_len;
                    w_busy    = 1'b1;
                    w_aborted = 1'b0;
                    if (cfg_len == '0) begin
                        w_done = 1'b1;
                    end else if (w_fill_req) begin
                        w_state = S_WR_REQ;
                        w_valid = 1'b1;
                        w_addr  = {cfg_dst[31:2], 2'b00};
                        w_wstrb = c_STRB_WR;
                        w_wdata = w_pattern;
                    end else begin
                        w_state = S_RD_REQ;
                        w_valid = 1'b1;
                        w_addr  = {cfg_src[31:2], 2'b00};
                        w_wstrb = c_STRB_RD;
                    end
                end
            end
            S_RD_REQ: begin
                if (w_xfer) begin
                    w_valid = 1'b0;
                    w_wdata = mem_rdata;
                    w_state = S_RD_GAP;
                end
            end
            S_RD_GAP: begin
                // abort here drops the word just read
                if (cfg_abort) begin
                    w_state   = S_IDLE;
                    w_busy    = 1'b0;
                    w_done    = 1'b1;
                    w_aborted = 1'b1;
                end else begin
                    w_state = S_WR_REQ;
                    w_valid = 1'b1;
                    w_addr  = r_dst;
                    w_wstrb = c_STRB_WR;
                end
            end
            S_WR_REQ: begin
                if (w_xfer) begin
                    w_valid = 1'b0;
                    w_dst   = r_dst + c_WORD;
                    if (!w_fill_mode) begin
                        w_src = r_src + c_WORD;
                    end
                    if (r_rem != '0) begin
                        w_rem = r_rem - LEN_W'(1);
                    end
                    w_state = S_WR_GAP;
                end
            end
            S_WR_GAP: begin
                if (cfg_abort || (r_rem == '0)) begin
                    w_state   = S_IDLE;
                    w_busy    = 1'b0;
                    w_done    = 1'b1;
                    w_aborted = cfg_abort;
                end else if (w_fill_mode) begin
                    w_state = S_WR_REQ;
                    w_valid = 1'b1;
                    w_addr  = r_dst;
                    w_wstrb = c_STRB_WR;
                end else begin
                    w_state = S_RD_REQ;
                    w_valid = 1'b1;
                    w_addr  = r_src;
                    w_wstrb = c_STRB_RD;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_valid = 1'b0;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign aborted   = r_aborted;
    assign mem_valid = r_valid;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;

endmodule
`default_nettype wire
